// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: registered ARM control decoder feeding the ID/EX pipeline boundary.
//
// Decodes mode/op_code/S_in into an execute control word and latches it each cycle.
// Flush inserts a bubble, freeze holds every register, and a failed condition check
// issues a NOP that keeps its slot valid but drives no controls.
//
// Optional feature: define CU_MUL_EN to decode mode 11 as a multi-cycle multiply.
// A multiply stalls the front end via `busy` for MUL_CYCLES cycles and then issues.
// With CU_MUL_EN undefined, mode 11 is a NOP, `busy` is tied low and no FSM is built.

module id_ctrl_stage #(
  parameter int unsigned EXE_W      = 4,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             S_in,
  input  logic             cond_pass,
  input  logic             freeze,
  input  logic             flush,
  output logic [EXE_W-1:0] exe_cmd_q,
  output logic             mem_read_q,
  output logic             mem_write_q,
  output logic             wb_en_q,
  output logic             s_out_q,
  output logic             b_q,
  output logic             valid_q,
  output logic             busy
);

  // Reject configurations the command encoding and stall counter cannot represent.
  if (EXE_W < 4) begin : g_exe_w_check
    $error("id_ctrl_stage: EXE_W must be at least 4");
  end
  if (MUL_CYCLES < 1) begin : g_mul_cycles_check
    $error("id_ctrl_stage: MUL_CYCLES must be at least 1");
  end

  // Execute command encodings (4-bit native, zero-extended to EXE_W).
  localparam logic [3:0] CmdNop = 4'b0000;
  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdMul = 4'b1010;

  // Instruction classes.
  localparam logic [1:0] ModeAlu = 2'b00;
  localparam logic [1:0] ModeMem = 2'b01;
  localparam logic [1:0] ModeBr  = 2'b10;
  localparam logic [1:0] ModeMul = 2'b11;

  // Data-processing opcodes.
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;
  localparam logic [3:0] OpMem = 4'b0100;

  // Raw decode of the instruction fields, independent of validity and condition.
  logic [3:0] dec_cmd;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_wb_en;
  logic       dec_s_out;
  logic       dec_b;

  // Slot word the normal (non-multiply) issue path would load.
  logic [EXE_W-1:0] ld_exe_cmd;
  logic             ld_mem_read;
  logic             ld_mem_write;
  logic             ld_wb_en;
  logic             ld_s_out;
  logic             ld_b;
  logic             ld_valid;

  // Next-state values of the ID/EX output registers.
  logic [EXE_W-1:0] exe_cmd_d;
  logic             mem_read_d;
  logic             mem_write_d;
  logic             wb_en_d;
  logic             s_out_d;
  logic             b_d;
  logic             valid_d;

`ifdef CU_MUL_EN
  // Counter only needs to hold MUL_CYCLES-1.
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mul_req;

  // A multiply only starts when it is real and its condition holds.
  assign mul_req = valid_in & cond_pass & (mode == ModeMul);
`endif

  // Field decode: mode/op_code/S_in to execute command and control enables.
  always_comb begin
    dec_cmd       = CmdNop;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wb_en     = 1'b0;
    dec_s_out     = 1'b0;
    dec_b         = 1'b0;
    case (mode)
      ModeAlu: begin
        case (op_code)
          OpMov: begin dec_cmd = CmdMov; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpMvn: begin dec_cmd = CmdMvn; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpAdd: begin dec_cmd = CmdAdd; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpAdc: begin dec_cmd = CmdAdc; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpSub: begin dec_cmd = CmdSub; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpSbc: begin dec_cmd = CmdSbc; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpAnd: begin dec_cmd = CmdAnd; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpOrr: begin dec_cmd = CmdOrr; dec_wb_en = 1'b1; dec_s_out = S_in; end
          OpEor: begin dec_cmd = CmdEor; dec_wb_en = 1'b1; dec_s_out = S_in; end
          // Compare/test only update flags, never write a register.
          OpCmp: begin dec_cmd = CmdSub; dec_s_out = 1'b1; end
          OpTst: begin dec_cmd = CmdAnd; dec_s_out = 1'b1; end
          default: ;
        endcase
      end
      ModeMem: begin
        if (op_code == OpMem) begin
          dec_cmd = CmdAdd;
          // S_in acts as the L bit: load writes back, store does not.
          if (S_in) begin
            dec_mem_read = 1'b1;
            dec_wb_en    = 1'b1;
          end else begin
            dec_mem_write = 1'b1;
          end
        end
      end
      ModeBr: begin
        dec_b = 1'b1;
      end
      ModeMul: begin
`ifdef CU_MUL_EN
        dec_cmd   = CmdMul;
        dec_wb_en = 1'b1;
        dec_s_out = S_in;
`endif
      end
      default: ;
    endcase
  end

  // Normal issue word: bubble when the slot is empty, NOP when the condition fails.
  always_comb begin
    ld_exe_cmd   = '0;
    ld_mem_read  = 1'b0;
    ld_mem_write = 1'b0;
    ld_wb_en     = 1'b0;
    ld_s_out     = 1'b0;
    ld_b         = 1'b0;
    ld_valid     = 1'b0;
    if (valid_in) begin
      ld_valid = 1'b1;
      if (cond_pass) begin
        ld_exe_cmd   = EXE_W'(dec_cmd);
        ld_mem_read  = dec_mem_read;
        ld_mem_write = dec_mem_write;
        ld_wb_en     = dec_wb_en;
        ld_s_out     = dec_s_out;
        ld_b         = dec_b;
      end
    end
  end

  // Next-state selection: flush beats freeze beats normal issue / multiply sequencing.
  always_comb begin
    // Default is a bubble; each branch below overrides as needed.
    exe_cmd_d   = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    wb_en_d     = 1'b0;
    s_out_d     = 1'b0;
    b_d         = 1'b0;
    valid_d     = 1'b0;
`ifdef CU_MUL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
`endif
    if (flush) begin
`ifdef CU_MUL_EN
      // Abort any multiply in flight.
      state_d = StIdle;
      cnt_d   = '0;
`endif
    end else if (freeze) begin
      exe_cmd_d   = exe_cmd_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      wb_en_d     = wb_en_q;
      s_out_d     = s_out_q;
      b_d         = b_q;
      valid_d     = valid_q;
    end else begin
`ifdef CU_MUL_EN
      if (state_q == StIdle) begin
        if (mul_req) begin
          cnt_d   = CntLast;
          state_d = StBusy;
        end else begin
          exe_cmd_d   = ld_exe_cmd;
          mem_read_d  = ld_mem_read;
          mem_write_d = ld_mem_write;
          wb_en_d     = ld_wb_en;
          s_out_d     = ld_s_out;
          b_d         = ld_b;
          valid_d     = ld_valid;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Upstream has held the multiply in IF/ID for the whole stall.
          exe_cmd_d = EXE_W'(CmdMul);
          wb_en_d   = 1'b1;
          s_out_d   = S_in;
          valid_d   = 1'b1;
          state_d   = StIdle;
        end
      end
`else
      exe_cmd_d   = ld_exe_cmd;
      mem_read_d  = ld_mem_read;
      mem_write_d = ld_mem_write;
      wb_en_d     = ld_wb_en;
      s_out_d     = ld_s_out;
      b_d         = ld_b;
      valid_d     = ld_valid;
`endif
    end
  end

  // ID/EX control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_cmd_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      s_out_q     <= 1'b0;
      b_q         <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      exe_cmd_q   <= exe_cmd_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_en_q     <= wb_en_d;
      s_out_q     <= s_out_d;
      b_q         <= b_d;
      valid_q     <= valid_d;
    end
  end

`ifdef CU_MUL_EN
  // Multiply sequencer state and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall upstream from the cycle a multiply appears until its last bubble cycle.
  assign busy = ((state_q == StIdle) & mul_req & ~flush) |
                ((state_q == StBusy) & (cnt_q != '0));
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: directed scoreboard bench for id_ctrl_stage (EXE_W = 6, MUL_CYCLES = 3).
// Multiply sequencing is exercised when CU_MUL_EN is defined; otherwise mode 11 is a NOP.

module tb_id_ctrl_stage;

  localparam int unsigned EXE_W      = 6;
  localparam int unsigned MUL_CYCLES = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [1:0]       mode;
  logic [3:0]       op_code;
  logic             S_in;
  logic             cond_pass;
  logic             freeze;
  logic             flush;
  logic [EXE_W-1:0] exe_cmd_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic             wb_en_q;
  logic             s_out_q;
  logic             b_q;
  logic             valid_q;
  logic             busy;

  always #5 clk = ~clk;

  id_ctrl_stage #(
    .EXE_W      (EXE_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .mode        (mode),
    .op_code     (op_code),
    .S_in        (S_in),
    .cond_pass   (cond_pass),
    .freeze      (freeze),
    .flush       (flush),
    .exe_cmd_q   (exe_cmd_q),
    .mem_read_q  (mem_read_q),
    .mem_write_q (mem_write_q),
    .wb_en_q     (wb_en_q),
    .s_out_q     (s_out_q),
    .b_q         (b_q),
    .valid_q     (valid_q),
    .busy        (busy)
  );

  typedef struct packed {
    logic [EXE_W-1:0] exe;
    logic             mr;
    logic             mw;
    logic             wb;
    logic             s;
    logic             b;
    logic             v;
  } word_t;

  word_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  localparam word_t Bubble = '0;

  function automatic word_t mk(input logic [3:0] exe, input logic mr, input logic mw,
                               input logic wb, input logic s, input logic b, input logic v);
    word_t w;
    w.exe = EXE_W'(exe);
    w.mr  = mr;
    w.mw  = mw;
    w.wb  = wb;
    w.s   = s;
    w.b   = b;
    w.v   = v;
    return w;
  endfunction

  task automatic drive(input logic vi, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic cp, input logic fz, input logic fl);
    valid_in  = vi;
    mode      = m;
    op_code   = op;
    S_in      = s;
    cond_pass = cp;
    freeze    = fz;
    flush     = fl;
  endtask

  task automatic check_out(input string tag);
    word_t o;
    word_t e;
    o = {exe_cmd_q, mem_read_q, mem_write_q, wb_en_q, s_out_q, b_q, valid_q};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  // Push the expected word, clock once, compare just after the edge.
  task automatic step(input string tag, input word_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // busy is combinational: let inputs settle, then compare before the edge.
  task automatic check_busy(input string tag, input logic e);
    #1;
    total++;
    assert (busy === e) else begin
      bad++;
      $error("FAIL %s: busy observed %b expected %b", tag, busy, e);
    end
  endtask

  initial begin
    // Reset held two cycles with a valid ADD presented.
    rst = 1'b1;
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    step("reset_0", Bubble);
    step("reset_1", Bubble);
    rst = 1'b0;
    step("add_after_reset", mk(4'b0010, 0, 0, 1, 0, 0, 1));

    // Decode sweep.
    drive(1'b1, 2'b01, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    step("ldr", mk(4'b0010, 1, 0, 1, 0, 0, 1));
    drive(1'b1, 2'b01, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    step("str", mk(4'b0010, 0, 1, 0, 0, 0, 1));
    drive(1'b1, 2'b00, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
    step("cmp", mk(4'b0100, 0, 0, 0, 1, 0, 1));
    drive(1'b1, 2'b00, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
    step("tst", mk(4'b0110, 0, 0, 0, 1, 0, 1));
    drive(1'b1, 2'b00, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    step("mvn_s", mk(4'b1001, 0, 0, 1, 1, 0, 1));
    drive(1'b1, 2'b00, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    step("sbc", mk(4'b0101, 0, 0, 1, 0, 0, 1));
    drive(1'b1, 2'b10, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0);
    step("branch", mk(4'b0000, 0, 0, 0, 0, 1, 1));
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step("mem_bad_op_nop", mk(4'b0000, 0, 0, 0, 0, 0, 1));
`ifndef CU_MUL_EN
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_busy("mode11_busy_off", 1'b0);
    step("mode11_nop", mk(4'b0000, 0, 0, 0, 0, 0, 1));
`endif

    // Condition fail and empty slot.
    drive(1'b1, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step("sub_cond_fail", mk(4'b0000, 0, 0, 0, 0, 0, 1));
    drive(1'b0, 2'b00, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    step("invalid_bubble", Bubble);

    // Freeze holds MOV while EOR waits; freeze+flush gives a bubble.
    drive(1'b1, 2'b00, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mov", mk(4'b0001, 0, 0, 1, 0, 0, 1));
    drive(1'b1, 2'b00, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("freeze_hold", mk(4'b0001, 0, 0, 1, 0, 0, 1));
    end
    drive(1'b1, 2'b00, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
    step("freeze_flush", Bubble);
    drive(1'b1, 2'b00, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    step("eor_s", mk(4'b1000, 0, 0, 1, 1, 0, 1));
    drive(1'b1, 2'b00, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b1);
    step("flush_drops_orr", Bubble);

`ifdef CU_MUL_EN
    // Multiply with flush in the presenting cycle never starts.
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
    check_busy("mul_flush_idle_busy", 1'b0);
    step("mul_flush_idle", Bubble);

    // Full multiply: busy T0..T2, issue after T3.
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_busy("mul_busy", 1'b1);
      step("mul_stall_bubble", Bubble);
    end
    check_busy("mul_busy_end", 1'b0);
    step("mul_issue", mk(4'b1010, 0, 0, 1, 1, 0, 1));

    // Freeze mid-multiply keeps busy high and the counter still.
    drive(1'b1, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_busy("mulz_t0_busy", 1'b1);
    step("mulz_t0", Bubble);
    freeze = 1'b1;
    check_busy("mulz_frozen_busy", 1'b1);
    step("mulz_frozen", Bubble);
    freeze = 1'b0;
    check_busy("mulz_t1_busy", 1'b1);
    step("mulz_t1", Bubble);
    check_busy("mulz_t2_busy", 1'b1);
    step("mulz_t2", Bubble);
    check_busy("mulz_t3_busy", 1'b0);
    step("mulz_issue", mk(4'b1010, 0, 0, 1, 0, 0, 1));

    // Abort: flush at T1, then a re-presented multiply restarts the full stall.
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check_busy("abort_t0_busy", 1'b1);
    step("abort_t0", Bubble);
    flush = 1'b1;
    step("abort_t1", Bubble);
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_busy("abort_t2_busy", 1'b0);
    step("abort_t2", Bubble);
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_busy("restart_busy", 1'b1);
      step("restart_bubble", Bubble);
    end
    check_busy("restart_busy_end", 1'b0);
    step("restart_issue", mk(4'b1010, 0, 0, 1, 1, 0, 1));
`endif

    // Back to normal decode afterwards.
    drive(1'b1, 2'b00, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
    check_busy("adc_busy", 1'b0);
    step("adc", mk(4'b0011, 0, 0, 1, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered, parametrised successor to the combinational ARM control decoder. It decodes `mode`/`op_code`/`S_in` and latches the control word into the ID/EX pipeline boundary. It honours hazard freeze and branch flush, squashes instructions that fail their condition check, and sequences an optional multi-cycle multiply that stalls the front end while it runs. It sits between the IF/ID register and the EXE stage and replaces the separate decoder plus ID/EX control flops.

## Interface
**Parameters**
- `EXE_W`, default 4: width of the execute command. Must be ≥ 4; all command codes are zero-extended to this width.
- `MUL_CYCLES`, default 3: number of stall cycles for a multiply. Must be ≥ 1.

**Ports**
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `valid_in`, input, 1: the IF/ID slot holds a real instruction.
- `mode`, input, 2: instruction class.
- `op_code`, input, 4: operation field.
- `S_in`, input, 1: S bit (or L bit for memory operations).
- `cond_pass`, input, 1: the condition check passed this cycle.
- `freeze`, input, 1: hazard stall from the hazard unit.
- `flush`, input, 1: branch taken; kill the ID/EX slot.
- `exe_cmd_q`, output, `EXE_W`: registered execute command.
- `mem_read_q`, output, 1: registered memory read enable.
- `mem_write_q`, output, 1: registered memory write enable.
- `wb_en_q`, output, 1: registered write-back enable.
- `s_out_q`, output, 1: registered flag-update enable.
- `b_q`, output, 1: registered branch indicator.
- `valid_q`, output, 1: the ID/EX slot holds an issued instruction (0 means bubble).
- `busy`, output, 1: combinational; the upstream stage must hold IF/ID while this is high.

## Operation
**Decode table** (mode, op_code → exe_cmd, other controls):
- Mode 00, S_out = S_in, wb_en = 1:
  - 1101 MOV → 0001
  - 1111 MVN → 1001
  - 0100 ADD → 0010
  - 0101 ADC → 0011
  - 0010 SUB → 0100
  - 0110 SBC → 0101
  - 0000 AND → 0110
  - 1100 ORR → 0111
  - 0001 EOR → 1000
- Mode 00, S_out = 1, wb_en = 0:
  - 1010 CMP → 0100
  - 1000 TST → 0110
- Mode 01, op 0100:
  - S_in = 1 (LDR): exe 0010, mem_read = 1, wb_en = 1.
  - S_in = 0 (STR): exe 0010, mem_write = 1.
- Mode 10, any op: b = 1, exe 0000, wb_en = 0.
- Mode 11, any op (multiply, only with `CU_MUL_EN`): exe 1010, wb_en = 1, S_out = S_in.
- Any other combination: NOP, all controls 0 with valid_q = 1.
- Any control field not listed for an entry is 0.

**Bubbles and NOPs**
- A bubble is all outputs 0, including valid_q.
- `valid_in` = 0 loads a bubble.
- `valid_in` = 1 with `cond_pass` = 0 loads a NOP (controls 0, valid_q = 1).

**Priority each edge:** `rst` > `flush` > `freeze` > normal.
- `rst`: all outputs 0, FSM to IDLE, counter to 0.
- `flush`: load a bubble, FSM to IDLE, counter to 0. A multiply in progress is aborted.
- `freeze`: all output registers, the FSM state and the counter hold.

**FSM**
- IDLE:
  - Non-multiply instruction: load the decoded word.
  - Multiply (valid_in & cond_pass & mode = 11): load a bubble, set cnt = MUL_CYCLES−1, go to BUSY.
- BUSY:
  - cnt ≠ 0: load a bubble, decrement cnt.
  - cnt = 0: load the multiply word from the inputs (still held upstream), go to IDLE.
- `busy` = (IDLE & multiply decode & ~flush) | (BUSY & cnt ≠ 0).

## Timing
- Decode-to-output latency is 1 cycle: instruction present at cycle T, outputs valid after the edge ending T.
- A multiply presented at T holds `busy` high for exactly MUL_CYCLES cycles (T … T+MUL_CYCLES−1). It issues after the edge ending T+MUL_CYCLES.
- `busy` does not depend on `freeze`. During freeze the counter does not advance, so `busy` stays high.
- `flush` together with a new instruction in the same cycle: the flush wins and the instruction is not captured. Upstream re-presents it, so this is not a loss.
- Outputs change only on clock edges. `busy` is the only combinational output.

## Configuration
- `CU_MUL_EN` defined: mode 11 decodes as multiply, and the FSM and counter are present.
- `CU_MUL_EN` undefined:
  - Mode 11 decodes as NOP.
  - `busy` is tied 0 and the FSM stays in IDLE.
  - `MUL_CYCLES` is ignored.

## Test plan
- Reset: hold rst for 2 cycles with valid ADD on the inputs → every output 0. First edge after release → exe_cmd_q = 0010, wb_en_q = 1, valid_q = 1.
- Decode sweep, EXE_W = 6:
  - mode 01, op 0100, S = 1 → exe_cmd_q = 000010, mem_read_q = 1, wb_en_q = 1.
  - S = 0 → mem_write_q = 1, wb_en_q = 0.
  - CMP → s_out_q = 1, wb_en_q = 0.
  - mode 11 without macro → NOP.
- Condition fail: SUB with S = 1 and cond_pass = 0 → valid_q = 1, all other outputs 0.
- Freeze/flush: MOV issued, then freeze for 3 cycles with EOR on the inputs → exe_cmd_q stays 0001. Assert freeze and flush together → bubble on the next edge.
- Multiply, MUL_CYCLES = 3, CU_MUL_EN defined: mode 11 at T0 → busy = 1 on T0–T2, 0 on T3; valid_q = 0 after T0–T2; exe_cmd_q = 1010, wb_en_q = 1 after T3.
- Multiply abort: same setup, flush at T1 → bubble, busy = 0 from T2. Re-presented multiply restarts a full 3-cycle stall.
